// File: rtl/riscv_dbg_pkg.sv
// Shared debug-readout types and constants.
// Contents: dump FSM state encoding and the byte width of the output stream.
// No logic; imported by the dump engine.
package riscv_dbg_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks read addresses 0..DEPTH-1 and streams each word LSB byte first.
// Latency: start -> LOAD next cycle, first byte the cycle after; NBYTES+1 cycles per register at full rate.
// Backpressure: out_valid/out_data hold while out_ready is low; nothing advances until a byte is accepted.
// Ports: clk, rst (sync, active-low) | start, busy, done | rd_addr/rd_data to the bank | out_valid/out_ready/out_data byte stream.
module regfile_dump
    import riscv_dbg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [$clog2(DEPTH)-1:0] rd_addr,
    input  logic [WIDTH-1:0]         rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W-1:0]        out_data,
    output logic                     busy,
    output logic                     done
);

    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        out_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // The bank reads asynchronously off the registered address,
                // so rd_data is settled by the end of this cycle.
                shift_d    = rd_data;
                byte_cnt_d = '0;
                state_d    = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (byte_cnt_q != LAST_BYTE) begin
                        shift_d    = shift_q >> BYTE_W;
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end else if (idx_q != LAST_IDX) begin
                        // Terminal test is an equality, so idx never wraps.
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    assign rd_addr  = idx_q;
    // Data is zeroed outside SEND so idle/reset output is a clean 0.
    assign out_data = out_valid ? shift_q[BYTE_W-1:0] : '0;

endmodule
